// File: rtl/ascon_data_packer.sv
// ascon_data_packer: packs a 32-bit little-endian word stream into padded 128-bit ASCON rate blocks.
// Optional msg_len_o running byte counter is built when ASCON_PACK_LEN_EN is defined.
module ascon_data_packer #(
    parameter int         IN_W     = 32,
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [IN_W-1:0] s_data_i,
    input  logic            s_valid_i,
    input  logic            s_last_i,
    input  logic [1:0]      s_bytes_i,
    output logic            s_ready_o,
    output logic [127:0]    block_o,
    output logic            block_valid_o,
    output logic            block_last_o,
    output logic [4:0]      block_bytes_o,
`ifdef ASCON_PACK_LEN_EN
    output logic [31:0]     msg_len_o,
`endif
    input  logic            block_ready_i
);

    if (IN_W != 32) begin : g_bad_width
        $error("ascon_data_packer: IN_W must be 32");
    end

    typedef enum logic [1:0] {FILL, FULL, PAD_ONLY} state_t;

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [4:0]   count_q, count_d;
    logic [127:0] block_q, block_d;
    logic         last_q, last_d;
    logic         pad_pending_q, pad_pending_d;

    logic [2:0]   word_bytes;
    logic [4:0]   fill_count;
    logic [127:0] merged;
    logic [127:0] pack_blk;

    // Unused slots of block_q are always zero, so the incoming word can simply be OR-ed in;
    // bytes at or above the new count are then replaced by the pad byte and zeros.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        word_bytes = (s_last_i && s_bytes_i != 2'd0) ? {1'b0, s_bytes_i} : 3'd4;
        fill_count = count_q + {2'b00, word_bytes};
        merged     = block_q | ({{(128-IN_W){1'b0}}, s_data_i} << {idx_q, 5'b00000});
        pack_blk   = '0;
        for (int b = 0; b < 16; b++) begin
            if (5'(b) < fill_count) begin
                pack_blk[8*b +: 8] = merged[8*b +: 8];
            end else if (s_last_i && 5'(b) == fill_count) begin
                pack_blk[8*b +: 8] = PAD_BYTE;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        block_d       = block_q;
        last_d        = last_q;
        pad_pending_d = pad_pending_q;
        s_ready_o     = 1'b0;
        block_valid_o = 1'b0;
        block_o       = '0;
        block_last_o  = 1'b0;
        block_bytes_o = '0;
        case (state_q)
            FILL: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    block_d = pack_blk;
                    count_d = fill_count;
                    idx_d   = idx_q + 2'd1;
                    if (s_last_i || idx_q == 2'd3) begin
                        state_d       = FULL;
                        last_d        = s_last_i && (fill_count != 5'd16);
                        pad_pending_d = s_last_i && (fill_count == 5'd16);
                    end
                end
            end
            FULL: begin
                block_valid_o = 1'b1;
                block_o       = block_q;
                block_last_o  = last_q;
                block_bytes_o = count_q;
                if (block_ready_i) begin
                    state_d = pad_pending_q ? PAD_ONLY : FILL;
                    idx_d   = '0;
                    count_d = '0;
                    block_d = '0;
                    last_d  = 1'b0;
                end
            end
            PAD_ONLY: begin
                block_valid_o = 1'b1;
                block_o       = {120'b0, PAD_BYTE};
                block_last_o  = 1'b1;
                if (block_ready_i) begin
                    pad_pending_d = 1'b0;
                    state_d       = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= FILL;
            idx_q         <= '0;
            count_q       <= '0;
            block_q       <= '0;
            last_q        <= 1'b0;
            pad_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            block_q       <= block_d;
            last_q        <= last_d;
            pad_pending_q <= pad_pending_d;
        end
    end

`ifdef ASCON_PACK_LEN_EN
    logic [31:0] len_q, len_d;

    always_comb begin
        len_d = len_q;
        if (s_valid_i && s_ready_o) begin
            len_d = len_q + 32'(word_bytes);
        end
        if (block_valid_o && block_ready_i && block_last_o) begin
            len_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    assign msg_len_o = len_q;
`endif

endmodule
